// File: rtl/noc_flit_depacketizer.sv
// noc_flit_depacketizer: reassembles head/tail framed flits into one MSG_W-bit
// message with a valid/ready output. A single-entry output hold lets the next
// packet's head be accepted in the same cycle as the message handshake.
// Optional: define NOC_DEPKT_ERR_CHECK_EN to add the msg_out_err framing flag.
module noc_flit_depacketizer #(
  parameter int FLIT_W = 32,
  parameter int MSG_W  = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  input  logic [FLIT_W-1:0] flit_in_data,
  input  logic              flit_in_head,
  input  logic              flit_in_tail,
  output logic              msg_out_valid,
  input  logic              msg_out_ready,
  output logic [MSG_W-1:0]  msg_out_data,
`ifdef NOC_DEPKT_ERR_CHECK_EN
  output logic              msg_out_err,
`endif
  output logic              busy
);

  localparam int N_FLITS = (MSG_W + FLIT_W - 1) / FLIT_W;
  localparam int CNT_W   = ($clog2(N_FLITS + 1) < 1) ? 1 : $clog2(N_FLITS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [MSG_W-1:0] buffer;
  logic             acc, start, append;

  // Only a held message can stall the input; that is the one comb path.
  assign flit_in_ready = (state != HOLD) || msg_out_ready;
  assign acc           = flit_in_valid && flit_in_ready;
  // In HOLD an accepted flit implies the handshake, so any accepted head starts a packet.
  assign start         = acc && flit_in_head;
  assign append        = acc && !flit_in_head && (state == COLLECT) &&
                         (cnt < CNT_W'(N_FLITS));
  assign msg_out_data  = buffer;

  // Next-state and slot-count decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (start)       cnt_nxt = CNT_W'(1);
    else if (append) cnt_nxt = cnt + CNT_W'(1);
    case (state)
      IDLE:    if (start) state_nxt = flit_in_tail ? HOLD : COLLECT;
      COLLECT: if (acc && flit_in_tail) state_nxt = HOLD;
      HOLD:    if (msg_out_ready)
                 state_nxt = start ? (flit_in_tail ? HOLD : COLLECT) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM with registered valid/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      msg_out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      msg_out_valid <= (state_nxt == HOLD);
      busy          <= (state_nxt != IDLE);
    end
  end

  // Assembly buffer: a head clears it so short packets read zero in unwritten
  // slots; appends OR into a slot known to be zero. Shift is below MSG_W since cnt<N_FLITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      buffer <= '0;
    else if (start)  buffer <= MSG_W'(flit_in_data);
    else if (append) buffer <= buffer | (MSG_W'(flit_in_data) << (int'(cnt) * FLIT_W));
  end

`ifdef NOC_DEPKT_ERR_CHECK_EN
  logic hs, stray, restart, over, new_msg, pend, pend_nxt;

  assign hs       = (state == HOLD) && msg_out_ready;
  assign stray    = acc && !flit_in_head && (state != COLLECT);
  assign restart  = start && (state == COLLECT);
  assign over     = acc && !flit_in_head && (state == COLLECT) && (cnt == CNT_W'(N_FLITS));
  assign new_msg  = acc && flit_in_tail && (start || (state == COLLECT));
  // Anomalies seen since the previous message handshake.
  assign pend_nxt = (hs ? 1'b0 : pend) | stray | restart | over;

  // Latch the framing verdict with each new message; drop it on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      msg_out_err <= 1'b0;
    end else begin
      pend <= new_msg ? 1'b0 : pend_nxt;
      if (new_msg)
        msg_out_err <= pend_nxt | (cnt_nxt < CNT_W'(N_FLITS));
      else if (hs)
        msg_out_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Randomized bench for noc_flit_depacketizer against a packet-level model:
// the model keeps the current packet's flits in a queue and a one-deep output
// slot, and builds each expected message from the first N flits on the tail.
module tb_noc_flit_depacketizer;
  localparam int FLIT_W = 32;
  localparam int MSG_W  = 80;
  localparam int N      = (MSG_W + FLIT_W - 1) / FLIT_W;
  localparam int WW     = MSG_W + FLIT_W;

  logic              clk, rst_n;
  logic              flit_in_valid, flit_in_ready, flit_in_head, flit_in_tail;
  logic [FLIT_W-1:0] flit_in_data;
  logic              msg_out_valid, msg_out_ready, busy;
  logic [MSG_W-1:0]  msg_out_data;
`ifdef NOC_DEPKT_ERR_CHECK_EN
  logic              msg_out_err;
`endif

  noc_flit_depacketizer #(.FLIT_W(FLIT_W), .MSG_W(MSG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
    .flit_in_data(flit_in_data), .flit_in_head(flit_in_head), .flit_in_tail(flit_in_tail),
    .msg_out_valid(msg_out_valid), .msg_out_ready(msg_out_ready),
    .msg_out_data(msg_out_data),
`ifdef NOC_DEPKT_ERR_CHECK_EN
    .msg_out_err(msg_out_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [FLIT_W-1:0] q[$];
  bit               m_inpkt, m_valid, m_err, m_anom;
  logic [MSG_W-1:0] m_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_inpkt = 0; m_valid = 0; m_err = 0; m_anom = 0; m_data = '0;
  endtask

  task automatic model_edge(input bit acc, input bit h, input bit t,
                            input logic [FLIT_W-1:0] d, input bit mr);
    logic [WW-1:0] wide;
    if (m_valid && mr) m_valid = 0;
    if (acc) begin
      if (h) begin
        if (m_inpkt) m_anom = 1;
        q.delete();
        q.push_back(d);
        m_inpkt = 1;
      end else if (m_inpkt) q.push_back(d);
      else m_anom = 1;
      if (t && m_inpkt) begin
        wide = '0;
        for (int k = 0; k < q.size() && k < N; k++)
          wide = wide | (WW'(q[k]) << (k * FLIT_W));
        m_data  = wide[MSG_W-1:0];
        m_err   = m_anom || (q.size() != N);
        m_valid = 1;
        m_anom  = 0;
        m_inpkt = 0;
        q.delete();
      end
    end
  endtask

  // One cycle: drive at negedge, check, advance model at posedge, return at negedge.
  task automatic step(input bit v, input bit h, input bit t,
                      input logic [FLIT_W-1:0] d, input bit mr);
    bit acc;
    flit_in_valid = v; flit_in_head = h; flit_in_tail = t;
    flit_in_data = d; msg_out_ready = mr;
    #1;
    chk("in_ready", flit_in_ready, !m_valid || mr);
    chk("out_valid", msg_out_valid, m_valid);
    chk("busy", busy, m_valid || m_inpkt);
    if (m_valid) begin
      chk("out_data", msg_out_data, m_data);
`ifdef NOC_DEPKT_ERR_CHECK_EN
      chk("out_err", msg_out_err, m_err);
`endif
    end
    acc = v && (!m_valid || mr);
    @(posedge clk);
    model_edge(acc, h, t, d, mr);
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_ready", flit_in_ready, 1);
    chk("rst_valid", msg_out_valid, 0);
    chk("rst_data", msg_out_data, 0);
    chk("rst_busy", busy, 0);
`ifdef NOC_DEPKT_ERR_CHECK_EN
    chk("rst_err", msg_out_err, 0);
`endif
  endtask

  // Asynchronous reset asserted mid-cycle, released at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 0;
    flit_in_valid = 0; flit_in_head = 0; flit_in_tail = 0; msg_out_ready = 0;
    #1;
    reset_checks();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pkt3(input logic [FLIT_W-1:0] base, input bit mr);
    step(1, 1, 0, base, mr);
    step(1, 0, 0, base + 1, mr);
    step(1, 0, 1, base + 2, mr);
  endtask

  initial begin
    rst_n = 0;
    flit_in_valid = 0; flit_in_head = 0; flit_in_tail = 0;
    flit_in_data = '0; msg_out_ready = 0;
    model_clear();
    #3;
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // reference packet
    step(1, 1, 0, 32'h11111111, 1);
    step(1, 0, 0, 32'h22222222, 1);
    step(1, 0, 1, 32'h0000AAAA, 1);
    chk("plan_msg", msg_out_data, 80'hAAAA_2222_2222_1111_1111);
    chk("plan_valid", msg_out_valid, 1);

    // back-to-back with ready=1
    pkt3(32'hA0000000, 1);
    pkt3(32'hB0000000, 1);

    // consumer stall for 5 cycles, then head accepted with the handshake
    for (int i = 0; i < 5; i++) step(1, 1, 0, 32'hC0000000, 0);
    chk("stall_data", msg_out_data, m_data);
    pkt3(32'hD0000000, 1);

    // short packet: upper 16 bits zero
    step(1, 1, 0, 32'h12345678, 1);
    step(1, 0, 1, 32'h9ABCDEF0, 1);
    chk("short_hi", msg_out_data[79:64], 0);
    // long packet: 4th flit discarded
    step(1, 1, 0, 32'h1, 1);
    step(1, 0, 0, 32'h2, 1);
    step(1, 0, 0, 32'h3, 1);
    step(1, 0, 1, 32'h4, 1);
    chk("long_msg", msg_out_data, 80'h0003_0000_0002_0000_0001);

    // stray then valid packet; head restart mid-packet
    step(1, 0, 0, 32'hDEADBEEF, 1);
    pkt3(32'hE0000000, 1);
    step(1, 1, 0, 32'h55555555, 1);
    step(1, 0, 0, 32'h66666666, 1);
    pkt3(32'hF0000000, 1);
    step(0, 0, 0, 32'h0, 1);

    // reset mid-collect and during hold
    step(1, 1, 0, 32'h77777777, 1);
    step(1, 0, 0, 32'h88888888, 1);
    do_reset();
    step(1, 0, 1, 32'h99999999, 1);
    step(0, 0, 0, 32'h0, 1);
    pkt3(32'h31000000, 0);
    step(0, 0, 0, 32'h0, 0);
    do_reset();
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) do_reset();
      step($urandom_range(99) < 70, $urandom_range(99) < 25,
           $urandom_range(99) < 35, $urandom, $urandom_range(99) < 60);
    end
    step(0, 0, 0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_flit_depacketizer.md
# noc_flit_depacketizer

Receive-side NoC network-interface block: accepts a stream of FLIT_W-bit flits framed by head/tail markers and reassembles them into one MSG_W-bit message, presented on a valid/ready output. It is the receiver counterpart of the flit packetizer and sits between the router ejection port and the AXI/AHB-side message consumer. It sustains back-to-back packets with no idle cycle between them when the consumer is ready.

## Interface
Parameters:
- FLIT_W, 32, flit payload width in bits (≥1)
- MSG_W, 80, reassembled message width in bits (≥1)
- Derived: N_FLITS = divceil(MSG_W, FLIT_W); CNT_W = log2c_1if1(N_FLITS+1) (noc_global functions)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flit_in_valid  in  1  flit present
- flit_in_ready  out  1  flit accepted when valid&&ready
- flit_in_data  in  FLIT_W  flit payload
- flit_in_head  in  1  first flit of packet
- flit_in_tail  in  1  last flit of packet (head&&tail = single-flit packet)
- msg_out_valid  out  1  message available
- msg_out_ready  in  1  consumer accepts message
- msg_out_data  out  MSG_W  reassembled message
- msg_out_err  out  1  framing error on current message (only with NOC_DEPKT_ERR_CHECK_EN)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- IDLE: flit_in_ready=1. Head accepted → clear assembly buffer, write flit to slot 0, cnt=1; if tail also set → HOLD, else → COLLECT. Non-head flit accepted in IDLE is dropped (stray).
- COLLECT: flit_in_ready=1. Each accepted flit writes slot cnt (bits [cnt*FLIT_W +: FLIT_W], truncated at MSG_W) while cnt<N_FLITS, then cnt saturates at N_FLITS; flits beyond N_FLITS are discarded. Accepted head in COLLECT restarts: buffer cleared, flit written to slot 0, cnt=1. Accepted tail → HOLD.
- HOLD: msg_out_valid=1, msg_out_data=buffer, stable until handshake. flit_in_ready=msg_out_ready. On handshake: accepted head in same cycle starts a new packet exactly as from IDLE (head&&tail → stay HOLD with new message); no flit → IDLE. Non-head flit accepted in that cycle is dropped.
- Unwritten slots (short packet) read as zero.
- Reset: state=IDLE, cnt=0, buffer=0; outputs flit_in_ready=1, msg_out_valid=0, msg_out_data=0, msg_out_err=0, busy=0. Reset mid-packet discards partial message with no output.

## Timing
- msg_out_valid rises the cycle after the tail handshake (1-cycle latency).
- N-flit packet: tail on cycle N, message valid cycle N+1; with msg_out_ready=1, next packet's head accepted on cycle N+1 → full throughput, no bubble.
- flit_in_ready depends combinationally on msg_out_ready only in HOLD; no other comb path input→output.
- msg_out_valid never drops without handshake; msg_out_data/err stable while valid&&!ready.

## Configuration
- NOC_DEPKT_ERR_CHECK_EN defined: msg_out_err port present; set with the message if final flit count ≠ N_FLITS (short or long), or if a head restarted collection, or if a stray flit was dropped since the previous message. Cleared on message handshake (re-evaluated for a message started in that cycle).
- Undefined: port and error logic removed; framing anomalies are silently handled as above.

## Test plan
- FLIT_W=32, MSG_W=80: 3 flits 0x11111111/0x22222222/0x0000AAAA (head, -, tail), ready=1 → one message 0xAAAA_22222222_11111111, valid one cycle after tail, err=0.
- Back-to-back two 3-flit packets, msg_out_ready=1 → flit_in_ready never low, messages on cycles 4 and 7.
- msg_out_ready held 0 for 5 cycles in HOLD → flit_in_ready=0, data stable; release → second head accepted same cycle as handshake.
- Short packet (head, tail only, 2 flits) → upper 16 bits zero, err=1 (macro on); 4-flit packet → 4th flit discarded, err=1.
- Stray non-head flit in IDLE then valid packet → stray dropped, message correct, err=1; head mid-packet → restart, message holds only new packet.
- rst_n asserted mid-COLLECT and during HOLD → all outputs to reset values immediately, no message emitted after release.
